ma_sample_feeder: RTL and testbench

//   Upstream pacing stage for the moving-average block. Accepts samples on a

---
 rtl/ma_sample_feeder.sv | 98 +++++++++
 tb/tb_ma_sample_feeder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_sample_feeder.sv
// Pacing stage for the moving-average block: a FIFO of opaque samples, each one
// presented on m_data with m_en held for STEP_CYCLES en-qualified clocks.
module ma_sample_feeder #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 8,
  parameter int STEP_CYCLES = 3,
  parameter int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_en,
  output logic [LVL_W-1:0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [AW:0]       wptr, rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push, pop, win_end;

  // Extra pointer bit distinguishes full from empty; occupancy is their difference.
  assign level   = LVL_W'(wptr - rptr);
  assign s_ready = (level != LVL_FULL) && !rst;
  assign push    = s_valid && s_ready && !flush;

  // A window only advances on cycles the downstream actually saw (en && m_en).
  assign win_end = (state == ISSUE) && en && m_en && (cnt == CNT_LAST);
  assign pop     = !flush && en && (level != '0) && ((state == IDLE) || win_end);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      state  <= IDLE;
      cnt    <= '0;
      m_en   <= 1'b0;
      m_data <= '0;
    end else if (flush) begin
      wptr   <= '0;
      rptr   <= '0;
      state  <= IDLE;
      cnt    <= '0;
      m_en   <= 1'b0;
      m_data <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop) begin
        rptr   <= rptr + PTR_ONE;
        m_data <= mem[rptr[AW-1:0]];
      end
      case (state)
        IDLE: begin
          if (pop) begin
            state <= ISSUE;
            m_en  <= 1'b1;
            cnt   <= '0;
          end
        end
        ISSUE: begin
          if (!en) begin
            m_en <= 1'b0;
          end else if (!m_en) begin
            // resuming after a stall: reopen the window, count untouched
            m_en <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            if (pop) begin
              cnt <= '0;
            end else begin
              m_en  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ma_sample_feeder.sv
// Randomized bench for ma_sample_feeder; the model is an ordered word list where
// every word must appear on m_data for exactly STEP en-qualified m_en cycles.
module tb_ma_sample_feeder;
  localparam int DW = 64, DEPTH = 8, STEP = 3, LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, flush = 1'b0, s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, m_en;
  logic [DW-1:0] m_data;
  logic [LW-1:0] level;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] obs_q[$];

  always #5 clk = ~clk;

  ma_sample_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_en(m_en), .level(level)
  );

  // Record every cycle the downstream consumes a sample.
  always @(negedge clk) if (m_en && en) obs_q.push_back(m_data);

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    int n = 0;
    s_data = w; s_valid = 1'b1;
    while (!s_ready && n < 200) begin tick(); n++; end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL push_timeout s_ready=%b required=1", s_ready);
    end else tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    checks += 4;
    if (m_en !== 1'b0)  begin errors++; $display("FAIL rst_m_en got=%b exp=0", m_en); end
    if (m_data !== '0)  begin errors++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
    if (level !== '0)   begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
    if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    tick();
    rst = 1'b0; #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rel_s_ready got=%b exp=1", s_ready); end
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    w = 64'h3FF0000000000000;
    apply_reset();
    en = 1'b1;
    obs_q.delete();
    push_word(w);
    checks += 2;
    if (m_en !== 1'b0) begin errors++; $display("FAIL single_bypass m_en=%b exp=0", m_en); end
    if (level !== 1)   begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
    for (int i = 0; i < STEP; i++) begin
      tick();
      checks += 2;
      if (m_en !== 1'b1) begin errors++; $display("FAIL single_m_en c%0d got=%b exp=1", i, m_en); end
      if (m_data !== w)  begin errors++; $display("FAIL single_data c%0d got=%h exp=%h", i, m_data, w); end
    end
    tick();
    checks += 2;
    if (m_en !== 1'b0) begin errors++; $display("FAIL single_end m_en=%b exp=0", m_en); end
    if (obs_q.size() != STEP) begin errors++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), STEP); end
  endtask

  task automatic test_burst();
    logic [DW-1:0] words[$];
    int ones = 0, rises = 0;
    logic prev = 1'b0;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      words.push_back(rnd_word());
      push_word(words[i]);
    end
    checks += 2;
    if (level !== LW'(DEPTH)) begin errors++; $display("FAIL burst_full_level got=%0d exp=%0d", level, DEPTH); end
    if (s_ready !== 1'b0)     begin errors++; $display("FAIL burst_s_ready got=%b exp=0", s_ready); end
    s_data = rnd_word(); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++;
    if (level !== LW'(DEPTH)) begin errors++; $display("FAIL burst_refuse level=%0d exp=%0d", level, DEPTH); end
    obs_q.delete();
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_en) ones++;
      if (m_en && !prev) rises++;
      prev = m_en;
    end
    checks += 4;
    if (ones != DEPTH*STEP) begin errors++; $display("FAIL burst_m_en_cycles got=%0d exp=%0d", ones, DEPTH*STEP); end
    if (rises != 1)         begin errors++; $display("FAIL burst_contiguous rises=%0d exp=1", rises); end
    if (level !== '0)       begin errors++; $display("FAIL burst_drain level=%0d exp=0", level); end
    if (obs_q.size() != DEPTH*STEP) begin errors++; $display("FAIL burst_obs got=%0d exp=%0d", obs_q.size(), DEPTH*STEP); end
    for (int i = 0; i < obs_q.size() && i < DEPTH*STEP; i++) begin
      checks++;
      if (obs_q[i] !== words[i/STEP]) begin errors++; $display("FAIL burst_order i=%0d got=%h exp=%h", i, obs_q[i], words[i/STEP]); end
    end
  endtask

  task automatic test_en_stall();
    logic [DW-1:0] w;
    w = rnd_word();
    apply_reset();
    en = 1'b1;
    obs_q.delete();
    push_word(w);
    tick();                      // first m_en cycle, en high
    checks++;
    if (m_en !== 1'b1) begin errors++; $display("FAIL stall_start m_en=%b exp=1", m_en); end
    tick();
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 2;
      if (m_en !== 1'b0) begin errors++; $display("FAIL stall_m_en c%0d got=%b exp=0", i, m_en); end
      if (m_data !== w)  begin errors++; $display("FAIL stall_hold c%0d got=%h exp=%h", i, m_data, w); end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks += 2;
    if (m_en !== 1'b0) begin errors++; $display("FAIL stall_end m_en=%b exp=0", m_en); end
    if (obs_q.size() != STEP) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), STEP); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== w) begin errors++; $display("FAIL stall_data i=%0d got=%h exp=%h", i, obs_q[i], w); end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] words[$];
    int total;
    total = 2*DEPTH + 3;
    apply_reset();
    for (int i = 0; i < total; i++) words.push_back(rnd_word());
    for (int i = 0; i < 4; i++) push_word(words[i]);
    checks++;
    if (level !== 4) begin errors++; $display("FAIL wrap_pre_level got=%0d exp=4", level); end
    obs_q.delete();
    en = 1'b1; s_data = words[4]; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    checks += 2;
    if (level !== 4)   begin errors++; $display("FAIL wrap_push_pop level=%0d exp=4", level); end
    if (m_en !== 1'b1) begin errors++; $display("FAIL wrap_first m_en=%b exp=1", m_en); end
    for (int i = 5; i < total; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        en = ($urandom_range(0, 3) != 0);
        tick();
      end
      en = 1'b1;
      push_word(words[i]);
    end
    en = 1'b1;
    for (int i = 0; i < 80; i++) tick();
    checks += 3;
    if (level !== '0)  begin errors++; $display("FAIL wrap_drain level=%0d exp=0", level); end
    if (m_en !== 1'b0) begin errors++; $display("FAIL wrap_idle m_en=%b exp=0", m_en); end
    if (obs_q.size() != total*STEP) begin errors++; $display("FAIL wrap_obs got=%0d exp=%0d", obs_q.size(), total*STEP); end
    for (int i = 0; i < obs_q.size() && i < total*STEP; i++) begin
      checks++;
      if (obs_q[i] !== words[i/STEP]) begin errors++; $display("FAIL wrap_order i=%0d got=%h exp=%h", i, obs_q[i], words[i/STEP]); end
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] fresh;
    fresh = rnd_word();
    apply_reset();
    for (int i = 0; i < 6; i++) push_word(rnd_word());
    en = 1'b1;
    tick();
    checks += 2;
    if (level !== 5)   begin errors++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
    if (m_en !== 1'b1) begin errors++; $display("FAIL flush_pre_m_en got=%b exp=1", m_en); end
    flush = 1'b1; s_valid = 1'b1; s_data = rnd_word();
    tick();
    flush = 1'b0; s_valid = 1'b0;
    checks += 3;
    if (m_en !== 1'b0) begin errors++; $display("FAIL flush_m_en got=%b exp=0", m_en); end
    if (level !== '0)  begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
    if (m_data !== '0) begin errors++; $display("FAIL flush_m_data got=%h exp=0", m_data); end
    obs_q.delete();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL flush_stale got=%0d exp=0", obs_q.size()); end
    push_word(fresh);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (obs_q.size() != STEP) begin errors++; $display("FAIL flush_fresh_count got=%0d exp=%0d", obs_q.size(), STEP); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== fresh) begin errors++; $display("FAIL flush_fresh i=%0d got=%h exp=%h", i, obs_q[i], fresh); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    en = 1'b1;
    push_word(rnd_word());
    push_word(rnd_word());
    checks++;
    if (m_en !== 1'b1) begin errors++; $display("FAIL rmid_pre m_en=%b exp=1", m_en); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (m_en !== 1'b0)  begin errors++; $display("FAIL rmid_m_en got=%b exp=0", m_en); end
    if (m_data !== '0)  begin errors++; $display("FAIL rmid_m_data got=%h exp=0", m_data); end
    if (level !== '0)   begin errors++; $display("FAIL rmid_level got=%0d exp=0", level); end
    tick();
    rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_replay got=%0d exp=0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_en_stall();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
